// File: rtl/dram_port_arbiter.sv
// Burst arbiter that shares one DRAM port between the core (M0) and a host loader (M1).
// Round-robin per burst by default; define DRAM_ARB_FIXED_PRIO_EN to make M0 always win ties.
module dram_port_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          Clk1,
  input  logic          Reset,

  input  logic          M0_Req,
  input  logic          M0_Wr,
  input  logic [AW-1:0] M0_Addr,
  input  logic [3:0]    M0_Len,
  input  logic [DW-1:0] M0_WData,
  output logic          M0_Gnt,
  output logic          M0_WAck,
  output logic          M0_RValid,
  output logic [DW-1:0] M0_RData,
  output logic          M0_Done,

  input  logic          M1_Req,
  input  logic          M1_Wr,
  input  logic [AW-1:0] M1_Addr,
  input  logic [3:0]    M1_Len,
  input  logic [DW-1:0] M1_WData,
  output logic          M1_Gnt,
  output logic          M1_WAck,
  output logic          M1_RValid,
  output logic [DW-1:0] M1_RData,
  output logic          M1_Done,

  output logic [AW-1:0] Addr,
  output logic          RD,
  output logic          WR,
  output logic [DW-1:0] DataOut,
  input  logic [DW-1:0] DataIn,
  output logic          Busy
);

  // state | meaning
  // IDLE  | no burst owns the port; arbitrate pending requests
  // GRANT | Gnt pulse; latch base address, direction and length
  // ISSUE | one DRAM access per cycle, base + i
  // DRAIN | wait for outstanding read words (one cycle for writes); Done pulse
  typedef enum logic [1:0] {IDLE, GRANT, ISSUE, DRAIN} state_t;

  state_t        state, state_nxt;
  logic          sel;          // 0 = M0, 1 = M1
  logic          pick;
  logic          wr_q;
  logic [3:0]    cnt;
  logic [3:0]    ret_cnt;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] hold_addr;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;
  logic          issue_rd;
  logic          issue_wr;
  logic          capture;
  logic          done_pulse;
  logic          any_req;

  assign any_req = M0_Req | M1_Req;

`ifdef DRAM_ARB_FIXED_PRIO_EN
  assign pick = ~M0_Req;
`else
  logic last;   // requester served most recently

  always_comb begin
    pick = M1_Req;
    if (M0_Req && M1_Req) pick = ~last;
  end

  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset)              last <= 1'b1;
    else if (state == GRANT) last <= sel;
  end
`endif

  assign issue_rd   = (state == ISSUE) && !wr_q;
  assign issue_wr   = (state == ISSUE) && wr_q;
  assign done_pulse = (state == DRAIN) && (wr_q || (rvalid_q && ret_cnt == 4'd0));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = GRANT;
      GRANT:   state_nxt = ISSUE;
      ISSUE:   if (cnt == 4'd0) state_nxt = DRAIN;
      DRAIN:   if (done_pulse) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read-return alignment: capture marks the cycle in which DataIn holds a valid word.
  generate
    if (RD_LAT == 0) begin : g_lat0
      assign capture = issue_rd;
    end else begin : g_latn
      logic [RD_LAT-1:0] rd_pipe;

      always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
          rd_pipe <= '0;
        end else begin
          rd_pipe[0] <= issue_rd;
          for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
      end

      assign capture = rd_pipe[RD_LAT-1];
    end
  endgenerate

  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      sel       <= 1'b0;
      wr_q      <= 1'b0;
      cnt       <= 4'd0;
      ret_cnt   <= 4'd0;
      cur_addr  <= '0;
      hold_addr <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state    <= state_nxt;
      rvalid_q <= capture;
      if (capture) rdata_q <= DataIn;
      if (rvalid_q && ret_cnt != 4'd0) ret_cnt <= ret_cnt - 4'd1;

      if (state == IDLE && any_req) sel <= pick;

      if (state == GRANT) begin
        wr_q     <= sel ? M1_Wr   : M0_Wr;
        cur_addr <= sel ? M1_Addr : M0_Addr;
        cnt      <= sel ? M1_Len  : M0_Len;
        ret_cnt  <= sel ? M1_Len  : M0_Len;
      end

      if (state == ISSUE) begin
        cur_addr  <= cur_addr + AW'(1);
        hold_addr <= cur_addr;
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
      end
    end
  end

  // Addr keeps showing the last issued address outside ISSUE.
  assign Addr    = (state == ISSUE) ? cur_addr : hold_addr;
  assign RD      = issue_rd;
  assign WR      = issue_wr;
  assign DataOut = issue_wr ? (sel ? M1_WData : M0_WData) : '0;
  assign Busy    = (state != IDLE);

  assign M0_Gnt    = (state == GRANT) && !sel;
  assign M1_Gnt    = (state == GRANT) &&  sel;
  assign M0_WAck   = issue_wr && !sel;
  assign M1_WAck   = issue_wr &&  sel;
  assign M0_RValid = rvalid_q && !sel;
  assign M1_RValid = rvalid_q &&  sel;
  assign M0_RData  = sel ? '0 : rdata_q;
  assign M1_RData  = sel ? rdata_q : '0;
  assign M0_Done   = done_pulse && !sel;
  assign M1_Done   = done_pulse &&  sel;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: burst table, arbitration order,
// mid-burst reset and a zero-latency instance; read data checked through a scoreboard.
module tb_dram_port_arbiter;

  localparam int RDL = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req;
  logic [1:0]  mwr;
  logic [15:0] maddr [2];
  logic [3:0]  mlen  [2];
  logic [15:0] mwd   [2];

  logic        m0_gnt, m0_wack, m0_rvalid, m0_done;
  logic        m1_gnt, m1_wack, m1_rvalid, m1_done;
  logic [15:0] rdata0, rdata1;
  logic [15:0] d_addr, d_dout, d_din;
  logic        d_rd, d_wr, d_busy;

  wire [1:0] gnt    = {m1_gnt, m0_gnt};
  wire [1:0] wack   = {m1_wack, m0_wack};
  wire [1:0] rvalid = {m1_rvalid, m0_rvalid};
  wire [1:0] done   = {m1_done, m0_done};

  logic [15:0] mem     [0:65535];
  logic [15:0] exp_mem [0:65535];
  logic [15:0] raddr_q;
  assign d_din = mem[raddr_q];

  dram_port_arbiter #(.AW(16), .DW(16), .RD_LAT(RDL)) u_dut (
    .Clk1(clk), .Reset(rst_n),
    .M0_Req(req[0]), .M0_Wr(mwr[0]), .M0_Addr(maddr[0]), .M0_Len(mlen[0]), .M0_WData(mwd[0]),
    .M0_Gnt(m0_gnt), .M0_WAck(m0_wack), .M0_RValid(m0_rvalid), .M0_RData(rdata0), .M0_Done(m0_done),
    .M1_Req(req[1]), .M1_Wr(mwr[1]), .M1_Addr(maddr[1]), .M1_Len(mlen[1]), .M1_WData(mwd[1]),
    .M1_Gnt(m1_gnt), .M1_WAck(m1_wack), .M1_RValid(m1_rvalid), .M1_RData(rdata1), .M1_Done(m1_done),
    .Addr(d_addr), .RD(d_rd), .WR(d_wr), .DataOut(d_dout), .DataIn(d_din), .Busy(d_busy)
  );

  // Zero read-latency instance, driven only on its M0 request line.
  logic        z_req = 1'b0;
  logic        z_gnt, z_wack, z_rvalid, z_done, z_rd, z_wr, z_busy;
  logic        z1_gnt, z1_wack, z1_rvalid, z1_done;
  logic [15:0] z_rdata, z1_rdata, z_addr, z_dout;
  wire  [15:0] z_din = mem[z_addr];

  dram_port_arbiter #(.AW(16), .DW(16), .RD_LAT(0)) u_lat0 (
    .Clk1(clk), .Reset(rst_n),
    .M0_Req(z_req), .M0_Wr(1'b0), .M0_Addr(16'h0010), .M0_Len(4'h0), .M0_WData(16'h0000),
    .M0_Gnt(z_gnt), .M0_WAck(z_wack), .M0_RValid(z_rvalid), .M0_RData(z_rdata), .M0_Done(z_done),
    .M1_Req(1'b0), .M1_Wr(1'b0), .M1_Addr(16'h0000), .M1_Len(4'h0), .M1_WData(16'h0000),
    .M1_Gnt(z1_gnt), .M1_WAck(z1_wack), .M1_RValid(z1_rvalid), .M1_RData(z1_rdata), .M1_Done(z1_done),
    .Addr(z_addr), .RD(z_rd), .WR(z_wr), .DataOut(z_dout), .DataIn(z_din), .Busy(z_busy)
  );

  // DRAM model: writes land at the edge, read data appears RDL=1 cycle after RD.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    for (int i = 0; i < 4; i++) mem[16 + i] = 16'h00A0 + 16'(i);
    raddr_q = 16'h0;
    forever begin
      @(posedge clk);
      if (d_wr) mem[d_addr] <= d_dout;
      if (d_rd) raddr_q <= d_addr;
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic sb_en = 1'b0;
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_strobes"}, {26'd0, d_busy, d_rd, d_wr, gnt, 1'b0}, 32'd0);
    chk({tag, "_handshake"}, {26'd0, wack, rvalid, done}, 32'd0);
    chk({tag, "_addr_dout"}, {d_addr, d_dout}, 32'd0);
    chk({tag, "_rdata"}, {rdata0, rdata1}, 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (d_busy && n < 100) begin @(negedge clk); n++; end
    chk("idle_timeout", {31'd0, d_busy}, 32'd0);
  endtask

  // Scoreboard side: compare every returned read word against the queued expectation.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (d_rd || d_wr) chk("rd_wr_exclusive", {31'd0, d_rd & d_wr}, 32'd0);
        if (sb_en && m0_rvalid) begin
          if (q0.size() == 0) chk("m0_unexpected_rvalid", 32'd1, 32'd0);
          else begin e = q0.pop_front(); chk("m0_rdata", {16'd0, rdata0}, {16'd0, e}); end
        end
        if (sb_en && m1_rvalid) begin
          if (q1.size() == 0) chk("m1_unexpected_rvalid", 32'd1, 32'd0);
          else begin e = q1.pop_front(); chk("m1_rdata", {16'd0, rdata1}, {16'd0, e}); end
        end
      end
    end
  end

  task automatic do_burst(input int m, input logic w, input logic [15:0] a, input logic [3:0] l,
                          input logic [15:0] db, input int exp_lat, output int gc, output int dc);
    int n, k, fr, ro, o;
    logic [15:0] ea;
    o = 1 - m;
    gc = -1; dc = -1;
    @(posedge clk); #1;
    mwr[m] = w; maddr[m] = a; mlen[m] = l; mwd[m] = db; req[m] = 1'b1;
    for (int i = 0; i <= int'(l); i++) begin
      ea = a + 16'(i);
      if (w) exp_mem[ea] = db + 16'(i);
      else if (m == 0) q0.push_back(exp_mem[ea]);
      else q1.push_back(exp_mem[ea]);
    end
    n = 0;
    while (!gnt[m] && n < 200) begin @(posedge clk); #1; n++; end
    req[m] = 1'b0;
    if (!gnt[m]) begin chk("gnt_timeout", 32'd0, 32'd1); return; end
    gc = cyc;
    n = 0; k = 0; fr = -1; ro = 0;
    while (n < 100) begin
      @(negedge clk);
      chk("busy_in_burst", {31'd0, d_busy}, 32'd1);
      chk("other_outputs_idle", {28'd0, gnt[o], wack[o], rvalid[o], done[o]}, 32'd0);
      if (d_rd || d_wr) begin
        if (k == 0) chk("first_issue_cycle", n, 32'd1);
        chk("strobe_dir", {30'd0, d_wr, d_rd}, w ? 32'd2 : 32'd1);
        chk("issue_addr", {16'd0, d_addr}, {16'd0, a + 16'(k)});
        if (w) begin
          chk("wack", {31'd0, wack[m]}, 32'd1);
          chk("dataout", {16'd0, d_dout}, {16'd0, db + 16'(k)});
        end
        k++;
      end
      if (rvalid[m]) begin
        if (fr < 0) fr = n;
        ro++;
      end
      if (done[m]) break;
      @(posedge clk); #1;
      n++;
      mwd[m] = db + 16'(k);
    end
    dc = cyc;
    chk("done_latency", n, exp_lat);
    chk("words_issued", k, int'(l) + 1);
    chk("rvalid_count", ro, w ? 0 : int'(l) + 1);
    if (!w) chk("first_rvalid_cycle", fr, 2 + RDL);
    @(negedge clk);
    chk("idle_after_done", {31'd0, d_busy}, 32'd0);
  endtask

  typedef struct {
    int          m;
    logic        w;
    logic [15:0] a;
    logic [3:0]  l;
    logic [15:0] db;
    int          lat;
  } vec_t;

  vec_t tbl [7];

  function automatic vec_t mk(input int m, input logic w, input logic [15:0] a,
                              input logic [3:0] l, input logic [15:0] db);
    vec_t v;
    v.m = m; v.w = w; v.a = a; v.l = l; v.db = db;
    v.lat = w ? int'(l) + 2 : int'(l) + 2 + RDL;
    return v;
  endfunction

  initial begin
    int gc, dc, gc1, dc1, ng, lastg, n, t0, t1, tv, td;
    logic [3:0] own_exp;
`ifdef DRAM_ARB_FIXED_PRIO_EN
    own_exp = 4'b0000;
`else
    own_exp = 4'b1010;
`endif
    for (int i = 0; i < 65536; i++) exp_mem[i] = 16'(i) ^ 16'h5A5A;
    for (int i = 0; i < 4; i++) exp_mem[16 + i] = 16'h00A0 + 16'(i);

    tbl[0] = mk(0, 1'b0, 16'h0010, 4'd3,  16'h0000);
    tbl[1] = mk(1, 1'b1, 16'hFFFE, 4'd2,  16'h0001);
    tbl[2] = mk(0, 1'b0, 16'hFFFE, 4'd2,  16'h0000);
    tbl[3] = mk(1, 1'b1, 16'h0100, 4'd0,  16'h0077);
    tbl[4] = mk(1, 1'b0, 16'h0100, 4'd0,  16'h0000);
    tbl[5] = mk(0, 1'b1, 16'h2000, 4'd15, 16'h1000);
    tbl[6] = mk(1, 1'b0, 16'h2000, 4'd15, 16'h0000);

    // Both requesters pending through reset, single-word reads.
    req = 2'b11; mwr = 2'b00;
    maddr[0] = 16'h0040; maddr[1] = 16'h0041;
    mlen[0] = 4'd0; mlen[1] = 4'd0; mwd[0] = 16'h0; mwd[1] = 16'h0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    ng = 0; lastg = 0; n = 0;
    while (ng < 4 && n < 100) begin
      @(negedge clk); n++;
      if (m0_gnt || m1_gnt) begin
        chk($sformatf("arb_owner%0d", ng), {31'd0, m1_gnt}, {31'd0, own_exp[ng]});
        if (ng > 0) chk("arb_gnt_spacing", cyc - lastg, 4 + RDL);
        lastg = cyc; ng++;
      end
    end
    chk("arb_gnt_count", ng, 4);
    req = 2'b00;
    wait_idle();
    repeat (2) @(negedge clk);
    sb_en = 1'b1;

    for (int i = 0; i < 7; i++)
      do_burst(tbl[i].m, tbl[i].w, tbl[i].a, tbl[i].l, tbl[i].db, tbl[i].lat, gc, dc);

    // M1 arrives while M0 runs a 16-word read; it must wait for M0's Done.
    fork
      do_burst(0, 1'b0, 16'h2000, 4'd15, 16'h0000, 17 + RDL, gc, dc);
      begin
        repeat (4) @(posedge clk);
        do_burst(1, 1'b1, 16'h0300, 4'd0, 16'hBEEF, 2, gc1, dc1);
      end
    join
    chk("m1_gnt_after_m0_done", gc1 - dc, 2);

    // Reset during word 2 of an 8-word read aborts it cleanly.
    sb_en = 1'b0;
    @(posedge clk); #1;
    mwr[0] = 1'b0; maddr[0] = 16'h0010; mlen[0] = 4'd7; req[0] = 1'b1;
    n = 0;
    while (!m0_gnt && n < 50) begin @(posedge clk); #1; n++; end
    chk("rst_burst_gnt", {31'd0, m0_gnt}, 32'd1);
    req[0] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midburst_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q0.delete(); q1.delete();
    sb_en = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m0_done || m0_rvalid || d_busy) n++;
    end
    chk("post_reset_quiet", n, 0);
    do_burst(0, 1'b0, 16'h0012, 4'd0, 16'h0000, 2 + RDL, gc, dc);

    // Zero-latency instance: RValid and Done two cycles after Gnt, re-grant four after.
    t0 = -1; t1 = -1; tv = -1; td = -1; n = 0;
    @(posedge clk); #1;
    z_req = 1'b1;
    while (n < 40 && t1 < 0) begin
      @(negedge clk);
      if (z_gnt) begin if (t0 < 0) t0 = n; else t1 = n; end
      if (z_rvalid && tv < 0) begin tv = n; chk("lat0_rdata", {16'd0, z_rdata}, 32'h00A0); end
      if (z_done && td < 0) td = n;
      n++;
    end
    z_req = 1'b0;
    chk("lat0_rvalid_cycle", tv - t0, 2);
    chk("lat0_done_cycle", td - t0, 2);
    chk("lat0_regrant_cycle", t1 - t0, 4);
    n = 0;
    while (z_busy && n < 50) begin @(negedge clk); n++; end
    chk("lat0_idle", {31'd0, z_busy}, 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q0.size() + q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single DRAM port (Addr/RD/WR/DataOut/DataIn) between two burst requesters: M0, the CVP14 core's memory interface, and M1, a host/debug loader used to preload and dump memory images.
- Arbitrates per burst: round-robin by default.
- Each granted burst issues consecutive-address single-word accesses, one per cycle.
- Handles read-latency draining before the port is handed to the other requester.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- RD_LAT, 1, cycles from the RD-high cycle until the DRAM's DataIn is valid (range 0..7).

Ports:
- Clk1  in  1  single system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- M0_Req  in  1  burst request; held high until M0_Gnt.
- M0_Wr  in  1  1 = write burst, 0 = read burst; sampled with Gnt.
- M0_Addr  in  AW  burst base address; sampled with Gnt.
- M0_Len  in  4  burst length minus 1 (0 = 1 word, 15 = 16 words); sampled with Gnt.
- M0_WData  in  DW  current write word.
- M0_Gnt  out  1  one-cycle pulse: request accepted, fields latched.
- M0_WAck  out  1  pulses in each cycle the current WData is driven to DRAM.
- M0_RValid  out  1  read word valid.
- M0_RData  out  DW  read word (registered).
- M0_Done  out  1  one-cycle pulse: burst complete.
- M1_Req, M1_Wr, M1_Addr, M1_Len, M1_WData, M1_Gnt, M1_WAck, M1_RValid, M1_RData, M1_Done: identical to the M0_* ports.
- Addr  out  AW  DRAM address.
- RD  out  1  DRAM read strobe.
- WR  out  1  DRAM write strobe.
- DataOut  out  DW  DRAM write data.
- DataIn  in  DW  DRAM read data.
- Busy  out  1  high from the Gnt cycle through the Done cycle.

Behaviour:
- Reset (Reset=0, asynchronous):
  - All outputs go to 0 and the state goes to IDLE.
  - Round-robin pointer is set to last=M1, so M0 wins the first tie.
  - Applying reset mid-burst aborts the burst immediately: no Done pulse, and no further RValid pulses.
- FSM states: IDLE, GRANT, ISSUE, DRAIN.
- IDLE:
  - With no Req, stay in IDLE.
  - With exactly one Req, select that requester.
  - With both Req high, select the requester that was not served last.
  - Go to GRANT.
- GRANT (cycle T):
  - Pulse Mx_Gnt and Busy rises.
  - Latch Addr, Wr and Len into a base register and a word counter.
  - Update the round-robin pointer to the selected requester.
- ISSUE (cycles T+1 .. T+1+Len):
  - Word i drives Addr = base + i, modulo 2^AW (0xFFFF wraps to 0x0000).
  - Write bursts: WR=1, DataOut=Mx_WData, Mx_WAck=1 in the same cycle; the requester presents the next word in the following cycle.
  - Read bursts: RD=1.
  - RD and WR are never both high.
  - While not in ISSUE: RD=WR=0, Addr holds its last value, DataOut=0.
- Write completion: after the last WR cycle, Mx_Done pulses in the next cycle, then return to IDLE.
- Read return timing:
  - A read issued in cycle t has DataIn sampled at the end of cycle t+RD_LAT.
  - Mx_RValid=1 with that word in Mx_RData during cycle t+RD_LAT+1.
  - Words return in order with no gaps.
- DRAIN (reads only):
  - Entered after the last RD cycle; holds until the last RValid.
  - Mx_Done pulses coincident with the final RValid, then return to IDLE.
- Timing limits:
  - The earliest next Gnt is 2 cycles after Done (IDLE, then GRANT).
  - Minimum single-word write: Gnt at T, WR at T+1, Done at T+2.
- Requests:
  - Req from the granted requester is ignored while Busy.
  - Req still high after Done counts as a new request.
  - The non-granted requester's Req is held pending and never dropped by the arbiter.
- RValid/WAck/Done/Gnt go only to the selected requester; the other requester's outputs stay 0.

Optional Feature:
- Macro DRAM_ARB_FIXED_PRIO_EN.
  - Defined: M0 always wins a simultaneous request; the round-robin pointer is removed. A burst in progress is still never pre-empted.
  - Undefined: round-robin as specified above.

Test Plan:
- M0 read, Addr=0x0010, Len=3, RD_LAT=1, memory holds 0xA0..0xA3:
  - Gnt at T; RD at T+1..T+4 with Addr 0x10..0x13.
  - RValid at T+3..T+6 with RData A0..A3; Done at T+6.
- M1 write, Addr=0xFFFE, Len=2, data 1,2,3:
  - WR at Addr FFFE, FFFF, 0000 with WAck each cycle; Done one cycle after the last WR.
  - Memory then reads back 1,2,3.
- M0_Req and M1_Req both held high from reset, Len=0 each:
  - Gnts alternate M0, M1, M0, M1.
  - With DRAM_ARB_FIXED_PRIO_EN: M0 only until M0_Req drops.
- M1 requests during an M0 16-word read burst:
  - M1_Gnt only after M0_Done; no RD/WR overlap.
  - Busy stays high through the M0 burst.
- Reset asserted mid-burst (after word 2 of a Len=7 read):
  - All outputs 0 immediately; no Done pulse.
  - After release, the next M0 request is granted normally starting from IDLE.
- RD_LAT=0 build, single-word read:
  - RValid at T+2, Done at T+2.
  - Next request granted at T+4.
